// File: rtl/ahb_slave.sv
// AHB-Lite slave front end for the AES core: decodes bus transfers into core strobes,
// inserts FIFO wait states and two-cycle ERROR responses. Optional macro: AHB_SIZE_CHECK_EN.
module ahb_slave (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSELx,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic [31:0] data_out,
    input  logic [7:0]  status,
    input  logic        rcv_fifo_full,
    input  logic        rcv_fifo_empty,
    input  logic        tx_fifo_empty,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic        rcv_enq_word,
    output logic        tx_deq_word,
    output logic        is_encrypt_pulse,
    output logic        is_decrypt_pulse,
    output logic        key_in
);

    typedef enum logic [2:0] {ST_IDLE, ST_XFER, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
    typedef enum logic [2:0] {RG_NONE, RG_STATUS, RG_ENC, RG_DEC, RG_KEY, RG_DATA, RG_TX} region_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    function automatic region_t decode_region(input logic [31:0] addr);
        region_t r;
        if (addr[31:8] != 24'h0) begin
            r = RG_NONE;
        end else begin
            case (addr[7:2]) inside
                6'd0:            r = RG_STATUS;
                6'd1:            r = RG_ENC;
                6'd2:            r = RG_DEC;
                [6'd4:6'd7]:     r = RG_KEY;
                [6'd16:6'd19]:   r = RG_DATA;
                [6'd32:6'd35]:   r = RG_TX;
                default:         r = RG_NONE;
            endcase
        end
        return r;
    endfunction

    function automatic logic is_read_region(input region_t r);
        return (r == RG_STATUS) || (r == RG_TX);
    endfunction

    // Back-pressure for a region, evaluated on the inputs seen at the current edge
    function automatic logic region_blocked(input region_t r, input logic rx_full,
                                            input logic rx_empty, input logic tx_empty);
        logic b;
        case (r)
            RG_KEY:  b = !rx_empty;
            RG_DATA: b = rx_full;
            RG_TX:   b = tx_empty;
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    region_t     pend_r;
    region_t     next_pend_s;
    region_t     addr_region_s;
    region_t     done_s;
    logic        accept_s;
    logic        illegal_s;
    logic        size_bad_s;
    logic        next_ready_s;
    logic [1:0]  next_resp_s;
    logic        unused_s;

    assign unused_s = ^{HBURST, HPROT, HSIZE, HWDATA, HADDR[1:0]};

`ifdef AHB_SIZE_CHECK_EN
    assign size_bad_s = (HSIZE != 3'b010);
`else
    assign size_bad_s = 1'b0;
`endif

    assign addr_region_s = decode_region(HADDR);
    // ERR2 shows HREADY = 1 but its address phase is discarded, so only IDLE/XFER accept
    assign accept_s  = HSELx && HTRANS[1] && HREADY &&
                       ((state_r == ST_IDLE) || (state_r == ST_XFER));
    assign illegal_s = (addr_region_s == RG_NONE) ||
                       (HWRITE == is_read_region(addr_region_s)) || size_bad_s;

    // Next data-phase state, response and the region completing at this edge
    always_comb begin
        next_state_s = ST_IDLE;
        next_pend_s  = pend_r;
        next_ready_s = 1'b1;
        next_resp_s  = RESP_OKAY;
        done_s       = RG_NONE;
        case (state_r)
            ST_IDLE, ST_XFER: begin
                if (!accept_s) begin
                    next_state_s = ST_IDLE;
                end else if (illegal_s) begin
                    next_state_s = ST_ERR1;
                    next_ready_s = 1'b0;
                    next_resp_s  = RESP_ERROR;
                end else if (region_blocked(addr_region_s, rcv_fifo_full,
                                            rcv_fifo_empty, tx_fifo_empty)) begin
                    next_state_s = ST_WAIT;
                    next_pend_s  = addr_region_s;
                    next_ready_s = 1'b0;
                end else begin
                    next_state_s = ST_XFER;
                    done_s       = addr_region_s;
                end
            end
            ST_WAIT: begin
                if (region_blocked(pend_r, rcv_fifo_full, rcv_fifo_empty, tx_fifo_empty)) begin
                    next_state_s = ST_WAIT;
                    next_ready_s = 1'b0;
                end else begin
                    next_state_s = ST_XFER;
                    done_s       = pend_r;
                end
            end
            ST_ERR1: begin
                next_state_s = ST_ERR2;
                next_resp_s  = RESP_ERROR;
            end
            ST_ERR2: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Registered state, bus response, read data and one-cycle strobes
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            state_r          <= ST_IDLE;
            pend_r           <= RG_NONE;
            HREADY           <= 1'b1;
            HRESP            <= RESP_OKAY;
            HRDATA           <= 32'h0;
            rcv_enq_word     <= 1'b0;
            tx_deq_word      <= 1'b0;
            is_encrypt_pulse <= 1'b0;
            is_decrypt_pulse <= 1'b0;
            key_in           <= 1'b0;
        end else begin
            state_r          <= next_state_s;
            pend_r           <= next_pend_s;
            HREADY           <= next_ready_s;
            HRESP            <= next_resp_s;
            if (done_s == RG_STATUS) begin
                HRDATA <= {24'h0, status};
            end else if (done_s == RG_TX) begin
                HRDATA <= data_out;
            end else begin
                HRDATA <= 32'h0;
            end
            rcv_enq_word     <= (done_s == RG_DATA);
            tx_deq_word      <= (done_s == RG_TX);
            is_encrypt_pulse <= (done_s == RG_ENC);
            is_decrypt_pulse <= (done_s == RG_DEC);
            key_in           <= (done_s == RG_KEY);
        end
    end

endmodule

// File: tb/tb_ahb_slave.sv
// Directed self-checking bench for ahb_slave (default build, HSIZE always word).
module tb_ahb_slave;

    logic        HCLK;
    logic        HRESETn;
    logic        HSELx;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] data_out;
    logic [7:0]  status;
    logic        rcv_fifo_full;
    logic        rcv_fifo_empty;
    logic        tx_fifo_empty;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic        rcv_enq_word;
    logic        tx_deq_word;
    logic        is_encrypt_pulse;
    logic        is_decrypt_pulse;
    logic        key_in;
    logic [4:0]  strobes;

    int checks;
    int failures;

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_KEY  = 5'b00001;
    localparam logic [4:0] S_DEC  = 5'b00010;
    localparam logic [4:0] S_ENC  = 5'b00100;
    localparam logic [4:0] S_TX   = 5'b01000;
    localparam logic [4:0] S_RCV  = 5'b10000;

    assign strobes = {rcv_enq_word, tx_deq_word, is_encrypt_pulse, is_decrypt_pulse, key_in};

    ahb_slave dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(HSELx), .HADDR(HADDR),
        .HBURST(HBURST), .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HWRITE(HWRITE), .data_out(data_out), .status(status),
        .rcv_fifo_full(rcv_fifo_full), .rcv_fifo_empty(rcv_fifo_empty),
        .tx_fifo_empty(tx_fifo_empty), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP), .rcv_enq_word(rcv_enq_word), .tx_deq_word(tx_deq_word),
        .is_encrypt_pulse(is_encrypt_pulse), .is_decrypt_pulse(is_decrypt_pulse),
        .key_in(key_in)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic write, input logic [1:0] trans);
        HSELx  = 1'b1;
        HADDR  = addr;
        HWRITE = write;
        HTRANS = trans;
        HWDATA = addr ^ 32'hA5A5_0000;
    endtask

    task automatic go_idle();
        HSELx  = 1'b0;
        HTRANS = 2'd0;
        HWRITE = 1'b0;
        HADDR  = 32'h0;
    endtask

    task automatic check_bus(input string tag, input logic ready, input logic [1:0] resp,
                             input logic [4:0] stb);
        check_eq({tag, "_hready"}, 32'(HREADY), 32'(ready));
        check_eq({tag, "_hresp"}, 32'(HRESP), 32'(resp));
        check_eq({tag, "_strobes"}, 32'(strobes), 32'(stb));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        HRESETn = 1'b1;
        HBURST = 3'd1;
        HPROT = 4'd3;
        HSIZE = 3'b010;
        data_out = 32'h0;
        status = 8'h00;
        rcv_fifo_full = 1'b0;
        rcv_fifo_empty = 1'b1;
        tx_fifo_empty = 1'b1;
        HWDATA = 32'h0;
        go_idle();

        // Reset for two cycles
        tick();
        tick();
        check_bus("reset", 1'b1, 2'b00, S_NONE);
        check_eq("reset_hrdata", HRDATA, 32'h0);
        HRESETn = 1'b0;
        tick();
        check_bus("idle", 1'b1, 2'b00, S_NONE);

        // Key burst directly followed by data burst, no bubbles
        for (int i = 0; i < 8; i++) begin
            drive((i < 4) ? 32'h10 + 32'(4 * i) : 32'h40 + 32'(4 * (i - 4)), 1'b1,
                  (i == 0 || i == 4) ? 2'd2 : 2'd3);
            tick();
            check_bus((i < 4) ? "key_burst" : "data_burst", 1'b1, 2'b00,
                      (i < 4) ? S_KEY : S_RCV);
        end
        go_idle();
        tick();
        check_bus("after_data_burst", 1'b1, 2'b00, S_NONE);

        // Key write stalled by a non-empty receive FIFO
        rcv_fifo_empty = 1'b0;
        drive(32'h10, 1'b1, 2'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bus("key_wait", 1'b0, 2'b00, S_NONE);
        end
        rcv_fifo_empty = 1'b1;
        tick();
        check_bus("key_release", 1'b1, 2'b00, S_KEY);
        for (int i = 1; i < 4; i++) begin
            drive(32'h10 + 32'(4 * i), 1'b1, 2'd3);
            tick();
            check_bus("key_rest", 1'b1, 2'b00, S_KEY);
        end
        go_idle();
        tick();
        check_bus("key_done", 1'b1, 2'b00, S_NONE);

        // Unmapped write at 0x128; the address presented in ERR cycle 2 is dropped
        drive(32'h128, 1'b1, 2'd2);
        tick();
        check_bus("err1", 1'b0, 2'b01, S_NONE);
        go_idle();
        tick();
        check_bus("err2", 1'b1, 2'b01, S_NONE);
        drive(32'h04, 1'b1, 2'd2);
        tick();
        check_bus("err_done", 1'b1, 2'b00, S_NONE);
        go_idle();
        tick();
        check_bus("err_discard", 1'b1, 2'b00, S_NONE);

        // Status read, status sampled at the address edge
        status = 8'hA5;
        drive(32'h00, 1'b0, 2'd2);
        tick();
        status = 8'h3C;
        check_eq("status_hrdata", HRDATA, 32'h0000_00A5);
        check_bus("status", 1'b1, 2'b00, S_NONE);
        go_idle();

        // Decrypt and encrypt selects, one cycle each
        drive(32'h08, 1'b1, 2'd2);
        tick();
        check_bus("decrypt", 1'b1, 2'b00, S_DEC);
        go_idle();
        tick();
        check_bus("decrypt_off", 1'b1, 2'b00, S_NONE);
        drive(32'h04, 1'b1, 2'd2);
        tick();
        check_bus("encrypt", 1'b1, 2'b00, S_ENC);
        go_idle();
        tick();
        check_bus("encrypt_off", 1'b1, 2'b00, S_NONE);

        // Transmit read stalled by an empty transmit FIFO
        tx_fifo_empty = 1'b1;
        data_out = 32'hDEAD_BEEF;
        drive(32'h84, 1'b0, 2'd2);
        tick();
        check_bus("tx_wait", 1'b0, 2'b00, S_NONE);
        tx_fifo_empty = 1'b0;
        tick();
        check_bus("tx_done", 1'b1, 2'b00, S_TX);
        check_eq("tx_hrdata", HRDATA, 32'hDEAD_BEEF);
        go_idle();
        tick();
        check_bus("tx_off", 1'b1, 2'b00, S_NONE);

        // Read of a write-only region errors, and never enqueues
        drive(32'h40, 1'b0, 2'd2);
        tick();
        check_bus("rd_dir_err1", 1'b0, 2'b01, S_NONE);
        go_idle();
        tick();
        check_bus("rd_dir_err2", 1'b1, 2'b01, S_NONE);
        tick();
        check_bus("rd_dir_okay", 1'b1, 2'b00, S_NONE);

        // Reset asserted during a data-write stall
        rcv_fifo_full = 1'b1;
        drive(32'h44, 1'b1, 2'd2);
        tick();
        check_bus("full_wait", 1'b0, 2'b00, S_NONE);
        HRESETn = 1'b1;
        tick();
        check_bus("stall_reset", 1'b1, 2'b00, S_NONE);
        HRESETn = 1'b0;
        rcv_fifo_full = 1'b0;
        go_idle();
        tick();
        check_bus("post_reset", 1'b1, 2'b00, S_NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_slave.md
Name: ahb_slave

Overview:
- AHB-Lite slave front end for the AES encrypt/decrypt core.
- Decodes single and INCR-burst transfers into:
  - encrypt/decrypt mode strobes,
  - a key-word load strobe,
  - receive-FIFO enqueue strobes,
  - transmit-FIFO dequeue strobes.
- Returns status and transmit data on HRDATA.
- Inserts wait states on FIFO back-pressure and issues two-cycle ERROR responses for illegal accesses.
- Downstream blocks capture HWDATA directly while the matching strobe is high.

Parameters:
- none

Ports:
- HCLK  in  1  bus clock; everything is sampled on the rising edge.
- HRESETn  in  1  synchronous reset, active-high (1 = reset).
- HSELx  in  1  slave select.
- HADDR  in  32  byte address.
- HBURST  in  3  burst type; accepted, not decoded.
- HPROT  in  4  protection; ignored.
- HSIZE  in  3  transfer size; ignored unless the optional feature is enabled.
- HTRANS  in  2  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- HWDATA  in  32  write data, valid in the data phase.
- HWRITE  in  1  1 = write.
- data_out  in  32  head word of the transmit FIFO.
- status  in  8  core status byte.
- rcv_fifo_full  in  1  receive FIFO full.
- rcv_fifo_empty  in  1  receive FIFO empty.
- tx_fifo_empty  in  1  transmit FIFO empty.
- HRDATA  out  32  read data.
- HREADY  out  1  transfer done / wait.
- HRESP  out  2  00 OKAY, 01 ERROR.
- rcv_enq_word  out  1  enqueue HWDATA into the receive FIFO.
- tx_deq_word  out  1  dequeue the transmit FIFO.
- is_encrypt_pulse  out  1  select encrypt mode.
- is_decrypt_pulse  out  1  select decrypt mode.
- key_in  out  1  HWDATA is a key word.

Behaviour:
- Reset values: HRDATA = 0, HREADY = 1, HRESP = 00, all strobes 0, internal state IDLE. Reset asserted mid-stall or mid-error returns to these values on the next edge.
- Address phase is accepted on an edge when HSELx = 1, HTRANS is NONSEQ or SEQ, and HREADY = 1. IDLE, BUSY, or HSELx = 0 means no action and OKAY.
- Decode rules:
  - HADDR[31:8] must be 0; otherwise the access is illegal.
  - The word is selected by HADDR[7:2]; HADDR[1:0] is ignored.
- Address map:
  - 0x00: read status.
  - 0x04: write, encrypt select.
  - 0x08: write, decrypt select.
  - 0x10–0x1C: write, key words (MSW first).
  - 0x40–0x4C: write, data words.
  - 0x80–0x8C: read, transmit data.
- Illegal accesses: a wrong direction to any decoded region, or any unmapped address.
- All outputs are registered. Each strobe is high for exactly the one data-phase cycle in which the transfer completes (HREADY = 1). No strobe fires during a wait cycle.
- Per-region response:
  - Encrypt/decrypt write: data phase has is_encrypt_pulse / is_decrypt_pulse = 1.
  - Key write: key_in = 1 in the data phase.
  - Data write: rcv_enq_word = 1 in the data phase.
  - Status read: HRDATA = {24'b0, status sampled at the address-phase edge}.
  - Transmit read: HRDATA = data_out and tx_deq_word = 1 in the completing cycle.
- Wait states: HREADY is driven low for the data phase while the blocking condition, sampled at the previous edge, holds.
  - Key write: blocked while rcv_fifo_empty = 0 (key load only with an empty receive FIFO).
  - Data write: blocked while rcv_fifo_full = 1.
  - Transmit read: blocked while tx_fifo_empty = 1.
  - HREADY returns to 1 on the edge after the condition clears; the strobe fires in that cycle.
  - Master holds HADDR/HTRANS while HREADY = 0; nothing new is accepted.
- ERROR response: cycle 1 HREADY = 0, HRESP = 01; cycle 2 HREADY = 1, HRESP = 01; then OKAY. Any address phase presented during cycle 2 is discarded. No strobe fires for an erroring transfer.
- Pipelining: back-to-back transfers, including a NONSEQ to a new region directly after a SEQ, complete one per cycle with no bubble when unblocked.
- Data-phase state machine: IDLE, XFER, WAIT, ERR1, ERR2.
- Simultaneous conditions: an ERROR has priority over wait states. A read never asserts rcv_enq_word.

Optional Feature:
- Macro AHB_SIZE_CHECK_EN.
- Defined: any accepted transfer with HSIZE ≠ 3'b010 receives the two-cycle ERROR response.
- Undefined: HSIZE is ignored and every transfer is treated as 32-bit.

Test Plan:
- Reset asserted 2 cycles -> HREADY = 1, HRESP = 00, all strobes 0.
- Key burst 0x10/0x14/0x18/0x1C with rcv_fifo_empty = 1 -> key_in = 1 for 4 consecutive data-phase cycles, HREADY stays 1.
- Key write 0x10 with rcv_fifo_empty = 0 for 3 cycles, then 1 -> HREADY = 0 throughout, HREADY = 1 one cycle after empty rises, then burst completes.
- Key burst immediately followed by data burst 0x40–0x4C -> rcv_enq_word = 1 during the last data phase, 0 the cycle after.
- Write 0x128 -> HREADY = 0 / HRESP = 01, then HREADY = 1 / HRESP = 01, then OKAY.
- status = 0xA5, read 0x00 -> HRDATA = 0x000000A5.
- Write 0x08 -> is_decrypt_pulse = 1 for one cycle.
- Write 0x04 -> is_encrypt_pulse = 1 for one cycle.
